// File: rtl/mips_mem_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto one single-port memory bus.
// One transaction in flight at a time; a watchdog converts a stalled access into an error ack.
module mips_mem_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255,
   parameter bit          FAIR    = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_err,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic              d_rd_wr,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_err,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd_wr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              busy,
   output logic              owner
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   state_e           r_state;
   state_e           w_state_next;
   logic             r_last_owner;
   logic [CNT_W-1:0] r_cnt;
   logic             w_grant;
   logic             w_grant_d;
   logic             w_timeout;

   assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

   always_comb begin
      w_state_next = r_state;
      w_grant      = 1'b0;
      // On contention the fair mode hands the bus to whoever did not have it last.
      if (i_req && d_req) begin
         w_grant_d = FAIR ? ~r_last_owner : 1'b1;
      end else begin
         w_grant_d = d_req;
      end
      unique case (r_state)
         StIdle: begin
            if (i_req || d_req) begin
               w_grant      = 1'b1;
               w_state_next = StBusy;
            end
         end
         StBusy: begin
            if (mem_ack || w_timeout) begin
               w_state_next = StResp;
            end
         end
         StResp:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         i_ack        <= 1'b0;
         i_rdata      <= '0;
         i_err        <= 1'b0;
         d_ack        <= 1'b0;
         d_rdata      <= '0;
         d_err        <= 1'b0;
         mem_req      <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_rd_wr    <= 1'b1;
         busy         <= 1'b0;
         owner        <= 1'b0;
         r_last_owner <= 1'b1;
         r_cnt        <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_grant) begin
                  owner   <= w_grant_d;
                  mem_req <= 1'b1;
                  busy    <= 1'b1;
                  r_cnt   <= '0;
                  if (w_grant_d) begin
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                     mem_rd_wr <= d_rd_wr;
                  end else begin
                     mem_addr  <= i_addr;
                     mem_rd_wr <= 1'b1;
                  end
               end
            end
            StBusy: begin
               // A mem_ack on the timeout edge takes precedence over the error.
               if (mem_ack || w_timeout) begin
                  mem_req      <= 1'b0;
                  r_last_owner <= owner;
                  if (owner) begin
                     d_ack <= 1'b1;
                     d_err <= ~mem_ack;
                     if (!mem_ack) begin
                        d_rdata <= '0;
                     end else if (mem_rd_wr) begin
                        d_rdata <= mem_rdata;
                     end
                  end else begin
                     i_ack   <= 1'b1;
                     i_err   <= ~mem_ack;
                     i_rdata <= mem_ack ? mem_rdata : '0;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            StResp: begin
               i_ack <= 1'b0;
               i_err <= 1'b0;
               d_ack <= 1'b0;
               d_err <= 1'b0;
               busy  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
